burst_rr_arbiter: RTL
=====================

Name: burst_rr_arbiter

Overview:
- Shares one burst-level memory port (the rd/wr burst request interface in front of aq_axi_master) between two clients, c0 and c1.
- Each client is a mem_test-style burst source. The arbiter grants one burst at a time, read or write, using round-robin over four request slots.
- It holds the grant until the downstream finish, then routes that burst's data handshakes to the granted client.
- It also provides a stuck-burst watchdog and per-slot grant counters for debug.

Parameters:
- DATA_BITS, 64, burst data width.
- ADDR_BITS, 32, burst address width.
- LEN_BITS, 10, burst length width (beats).
- TIMEOUT_CYC, 65536, cycles a grant may stay open before timeout is flagged; minimum 2.
- CNT_BITS, 16, width of each grant counter.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- c{0,1}_rd_burst_req  in  1 each  client read request; level, held until that client's rd finish.
- c{0,1}_wr_burst_req  in  1 each  client write request; level, held until that client's wr finish.
- c{0,1}_rd_burst_addr / c{0,1}_wr_burst_addr  in  ADDR_BITS each  burst start address.
- c{0,1}_rd_burst_len / c{0,1}_wr_burst_len  in  LEN_BITS each  burst length.
- c{0,1}_wr_burst_data  in  DATA_BITS each  client write data.
- c{0,1}_wr_burst_data_req  out  1 each  write data pop strobe.
- c{0,1}_rd_burst_data_valid  out  1 each  read data strobe.
- c{0,1}_rd_burst_finish / c{0,1}_wr_burst_finish  out  1 each  burst done pulse.
- rd_burst_data_out  out  DATA_BITS  read data, broadcast to both clients.
- m_rd_burst_req / m_wr_burst_req  out  1  downstream request.
- m_rd_burst_addr / m_wr_burst_addr  out  ADDR_BITS  downstream address, registered at grant.
- m_rd_burst_len / m_wr_burst_len  out  LEN_BITS  downstream length, registered at grant.
- m_wr_burst_data  out  DATA_BITS  muxed write data.
- m_wr_burst_data_req  in  1  downstream write data pop.
- m_rd_burst_data_valid  in  1  downstream read data strobe.
- m_rd_burst_data  in  DATA_BITS  downstream read data.
- m_rd_burst_finish / m_wr_burst_finish  in  1  downstream done pulses.
- grant  out  2  encoded slot of the current or last grant.
- busy  out  1  high while a grant is open.
- timeout  out  1  sticky watchdog flag.
- grant_cnt0..3  out  CNT_BITS each  per-slot grant counters.

Behaviour:
- Reset values:
  - State IDLE.
  - All m_* outputs, every client strobe, busy and timeout are 0.
  - grant = 3, so slot 0 has top priority after reset.
  - All counters are 0.
  - The round-robin pointer is 3.
- Slots: 0 = c0_wr, 1 = c0_rd, 2 = c1_wr, 3 = c1_rd.
- State machine IDLE -> BUSY -> GAP -> IDLE.
  - IDLE: if any slot requests, pick the first requesting slot after grant (modulo 4). In the same edge:
    - register grant, addr and len;
    - raise m_rd_burst_req or m_wr_burst_req;
    - set busy, clear the watchdog, and increment that slot's grant_cnt (wraps).
    - If no slot requests, stay in IDLE.
  - BUSY: the downstream request stays high. The finish matching the slot type moves the FSM to GAP on the next edge. That edge drops m_*_req and busy.
  - GAP: exactly one cycle. Client requests are not sampled, so a client deasserting its req off its finish is never regranted. Next state is IDLE.
- Routing is combinational, zero latency, and active only in BUSY.
  - m_wr_burst_data = granted client's wr data.
  - The granted client's wr_burst_data_req = m_wr_burst_data_req.
  - The granted client's rd_burst_data_valid = m_rd_burst_data_valid.
  - Finish pulses are routed to the granted client and slot type only.
  - Non-granted clients see 0 on all strobes.
- rd_burst_data_out = m_rd_burst_data at all times.
- Downstream strobes or finishes arriving outside BUSY, or of the wrong type (e.g. wr finish during a rd grant), are dropped. They do not change state.
- Latency: request to m_*_req high is 1 cycle from IDLE. The minimum gap between consecutive grants is 2 cycles (GAP + IDLE).
- Watchdog: a counter runs in BUSY.
  - Reaching TIMEOUT_CYC-1 without finish sets timeout. timeout stays set until reset.
  - The grant is NOT revoked.
  - The counter saturates.
- A client withdrawing req while granted is a protocol violation. The grant stays open until finish.
- ARESETN low mid-burst: asynchronous clear to reset values immediately. There is no pending-state recovery.

Decomposition:
- Package burst_arb_pkg holds:
  - slot encoding constants SLOT_C0_WR=0, SLOT_C0_RD=1, SLOT_C1_WR=2, SLOT_C1_RD=3;
  - the state enum IDLE/BUSY/GAP;
  - the slot type helper constant (bit 0 = read).
- One sub-module, rr_pick4: combinational 4-request round-robin picker (req[3:0], last[1:0] -> valid, sel[1:0]).

Test Plan:
- Single write: c0_wr_burst_req=1, addr=0x100, len=128 -> next cycle m_wr_burst_req=1, m_wr_burst_addr=0x100; 128 m_wr_burst_data_req pulses reach only c0; finish -> c0_wr_burst_finish pulse, m_wr_burst_req=0 one cycle later, grant_cnt0=1.
- All four slots request continuously after reset -> grant order 0,1,2,3,0; each m_*_req rise is at least 2 cycles after the previous finish.
- Read routing: c1 rd granted, 16 m_rd_burst_data_valid beats with data 0..15 -> c1_rd_burst_data_valid pulses 16 times, c0 strobes stay 0, rd_burst_data_out tracks data.
- Stray events: m_wr_burst_finish during a c0 rd grant, and m_rd_burst_finish in IDLE -> no state change, no client pulse.
- Watchdog with TIMEOUT_CYC=8: grant issued, no finish -> timeout=1 at 8th BUSY cycle, busy stays 1; a later finish closes the grant while timeout stays 1.
- Reset mid-burst: ARESETN low during BUSY -> same-cycle m_*_req=0, busy=0, counters 0; after release, c1_rd-only request is granted first as slot 3.

Source files
------------

// File: rtl/burst_arb_pkg.sv
// Shared constants and types for the two-client burst round-robin arbiter.
package burst_arb_pkg;

  // Request slot encoding; bit 0 of a slot index marks a read slot
  localparam logic [1:0] SLOT_C0_WR = 2'd0;
  localparam logic [1:0] SLOT_C0_RD = 2'd1;
  localparam logic [1:0] SLOT_C1_WR = 2'd2;
  localparam logic [1:0] SLOT_C1_RD = 2'd3;

  // Slot type bit: set for read slots
  localparam int unsigned SLOT_RD_BIT = 0;
  // Slot client bit: set for client 1
  localparam int unsigned SLOT_CLIENT_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first requester after 'last', modulo 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] sel
);

  logic [1:0] idx;

  // Scan slots last+1 .. last+4 and keep the first one requesting
  always_comb begin
    valid = 1'b0;
    sel   = last;
    idx   = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter sharing one burst memory port between two burst clients.
module burst_rr_arbiter
  import burst_arb_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 64,
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned LEN_BITS    = 10,
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter int unsigned CNT_BITS    = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  // Client 0
  input  logic                 c0_rd_burst_req,
  input  logic                 c0_wr_burst_req,
  input  logic [ADDR_BITS-1:0] c0_rd_burst_addr,
  input  logic [ADDR_BITS-1:0] c0_wr_burst_addr,
  input  logic [LEN_BITS-1:0]  c0_rd_burst_len,
  input  logic [LEN_BITS-1:0]  c0_wr_burst_len,
  input  logic [DATA_BITS-1:0] c0_wr_burst_data,
  output logic                 c0_wr_burst_data_req,
  output logic                 c0_rd_burst_data_valid,
  output logic                 c0_rd_burst_finish,
  output logic                 c0_wr_burst_finish,
  // Client 1
  input  logic                 c1_rd_burst_req,
  input  logic                 c1_wr_burst_req,
  input  logic [ADDR_BITS-1:0] c1_rd_burst_addr,
  input  logic [ADDR_BITS-1:0] c1_wr_burst_addr,
  input  logic [LEN_BITS-1:0]  c1_rd_burst_len,
  input  logic [LEN_BITS-1:0]  c1_wr_burst_len,
  input  logic [DATA_BITS-1:0] c1_wr_burst_data,
  output logic                 c1_wr_burst_data_req,
  output logic                 c1_rd_burst_data_valid,
  output logic                 c1_rd_burst_finish,
  output logic                 c1_wr_burst_finish,
  // Read data broadcast
  output logic [DATA_BITS-1:0] rd_burst_data_out,
  // Downstream port
  output logic                 m_rd_burst_req,
  output logic                 m_wr_burst_req,
  output logic [ADDR_BITS-1:0] m_rd_burst_addr,
  output logic [ADDR_BITS-1:0] m_wr_burst_addr,
  output logic [LEN_BITS-1:0]  m_rd_burst_len,
  output logic [LEN_BITS-1:0]  m_wr_burst_len,
  output logic [DATA_BITS-1:0] m_wr_burst_data,
  input  logic                 m_wr_burst_data_req,
  input  logic                 m_rd_burst_data_valid,
  input  logic [DATA_BITS-1:0] m_rd_burst_data,
  input  logic                 m_rd_burst_finish,
  input  logic                 m_wr_burst_finish,
  // Status / debug
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 timeout,
  output logic [CNT_BITS-1:0]  grant_cnt0,
  output logic [CNT_BITS-1:0]  grant_cnt1,
  output logic [CNT_BITS-1:0]  grant_cnt2,
  output logic [CNT_BITS-1:0]  grant_cnt3
);

  localparam int unsigned WD_BITS = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_BITS-1:0] WD_MAX = WD_BITS'(TIMEOUT_CYC - 1);
  localparam logic [WD_BITS-1:0] WD_PRE = WD_BITS'(TIMEOUT_CYC - 2);

  arb_state_e             state_q;
  logic [1:0]             grant_q;
  logic                   busy_q;
  logic                   timeout_q;
  logic [WD_BITS-1:0]     wd_q;
  logic                   m_rd_req_q;
  logic                   m_wr_req_q;
  logic [ADDR_BITS-1:0]   m_rd_addr_q;
  logic [ADDR_BITS-1:0]   m_wr_addr_q;
  logic [LEN_BITS-1:0]    m_rd_len_q;
  logic [LEN_BITS-1:0]    m_wr_len_q;
  logic [CNT_BITS-1:0]    cnt_q [4];

  logic [3:0]             slot_req;
  logic                   pick_valid;
  logic [1:0]             pick_sel;
  logic                   pick_c1;
  logic                   slot_finish;

  assign slot_req = {c1_rd_burst_req, c1_wr_burst_req, c0_rd_burst_req, c0_wr_burst_req};
  assign pick_c1  = pick_sel[SLOT_CLIENT_BIT];

  // Only the finish that matches the granted slot's type closes the grant
  assign slot_finish = grant_q[SLOT_RD_BIT] ? m_rd_burst_finish : m_wr_burst_finish;

  rr_pick4 u_pick (
    .req   (slot_req),
    .last  (grant_q),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // Grant FSM with registered downstream request, address, length and debug state
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      grant_q     <= 2'd3;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
      m_rd_req_q  <= 1'b0;
      m_wr_req_q  <= 1'b0;
      m_rd_addr_q <= '0;
      m_wr_addr_q <= '0;
      m_rd_len_q  <= '0;
      m_wr_len_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q         <= BUSY;
            grant_q         <= pick_sel;
            busy_q          <= 1'b1;
            wd_q            <= '0;
            cnt_q[pick_sel] <= cnt_q[pick_sel] + 1'b1;
            if (pick_sel[SLOT_RD_BIT]) begin
              m_rd_req_q  <= 1'b1;
              m_rd_addr_q <= pick_c1 ? c1_rd_burst_addr : c0_rd_burst_addr;
              m_rd_len_q  <= pick_c1 ? c1_rd_burst_len : c0_rd_burst_len;
            end else begin
              m_wr_req_q  <= 1'b1;
              m_wr_addr_q <= pick_c1 ? c1_wr_burst_addr : c0_wr_burst_addr;
              m_wr_len_q  <= pick_c1 ? c1_wr_burst_len : c0_wr_burst_len;
            end
          end
        end
        BUSY: begin
          if (slot_finish) begin
            state_q    <= GAP;
            m_rd_req_q <= 1'b0;
            m_wr_req_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            // Saturating watchdog; flag is sticky and never revokes the grant
            if (wd_q != WD_MAX) begin
              wd_q <= wd_q + 1'b1;
            end
            if (wd_q == WD_PRE) begin
              timeout_q <= 1'b1;
            end
          end
        end
        GAP: begin
          // Requests are ignored here so a client dropping req off finish is not regranted
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Zero-latency routing of data strobes and finishes to the granted client, BUSY only
  always_comb begin
    c0_wr_burst_data_req   = 1'b0;
    c0_rd_burst_data_valid = 1'b0;
    c0_rd_burst_finish     = 1'b0;
    c0_wr_burst_finish     = 1'b0;
    c1_wr_burst_data_req   = 1'b0;
    c1_rd_burst_data_valid = 1'b0;
    c1_rd_burst_finish     = 1'b0;
    c1_wr_burst_finish     = 1'b0;
    m_wr_burst_data        = '0;
    if (state_q == BUSY) begin
      m_wr_burst_data = grant_q[SLOT_CLIENT_BIT] ? c1_wr_burst_data : c0_wr_burst_data;
      unique case (grant_q)
        SLOT_C0_WR: begin
          c0_wr_burst_data_req = m_wr_burst_data_req;
          c0_wr_burst_finish   = m_wr_burst_finish;
        end
        SLOT_C0_RD: begin
          c0_rd_burst_data_valid = m_rd_burst_data_valid;
          c0_rd_burst_finish     = m_rd_burst_finish;
        end
        SLOT_C1_WR: begin
          c1_wr_burst_data_req = m_wr_burst_data_req;
          c1_wr_burst_finish   = m_wr_burst_finish;
        end
        SLOT_C1_RD: begin
          c1_rd_burst_data_valid = m_rd_burst_data_valid;
          c1_rd_burst_finish     = m_rd_burst_finish;
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_burst_data_out = m_rd_burst_data;
  assign m_rd_burst_req    = m_rd_req_q;
  assign m_wr_burst_req    = m_wr_req_q;
  assign m_rd_burst_addr   = m_rd_addr_q;
  assign m_wr_burst_addr   = m_wr_addr_q;
  assign m_rd_burst_len    = m_rd_len_q;
  assign m_wr_burst_len    = m_wr_len_q;
  assign grant             = grant_q;
  assign busy              = busy_q;
  assign timeout           = timeout_q;
  assign grant_cnt0        = cnt_q[0];
  assign grant_cnt1        = cnt_q[1];
  assign grant_cnt2        = cnt_q[2];
  assign grant_cnt3        = cnt_q[3];

endmodule
